// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared op codes and types for the branch controller
// Purpose: pc_op encodings and the op-code type shared by branch_ctrl and its bench.
// Ports: none (package).
package branch_pkg;

  localparam int OP_W = 3;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_JMP  = 3'b000;
  localparam op_t OP_JZ   = 3'b001;
  localparam op_t OP_JNZ  = 3'b010;
  localparam op_t OP_NOP  = 3'b011;
  localparam op_t OP_JGT  = 3'b100;
  localparam op_t OP_JLT  = 3'b101;
  localparam op_t OP_CALL = 3'b110;
  localparam op_t OP_RET  = 3'b111;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - LIFO return-address stack
// Purpose: holds return addresses pushed by CALL and popped by RET.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, pop       synchronous push / pop strobes (ignored when full / empty)
//   din             address to push
//   dout            current top-of-stack (valid when !empty)
//   full, empty     occupancy status
module ret_stack #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] r_mem [STACK_DEPTH];
  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_sp_dec;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_top_idx;

  // r_sp counts entries: the next free slot is r_sp, the top entry is r_sp-1.
  assign w_sp_dec  = r_sp - {{(SP_W-1){1'b0}}, 1'b1};
  assign w_wr_idx  = r_sp[AW-1:0];
  assign w_top_idx = w_sp_dec[AW-1:0];

  assign full  = (r_sp == SP_W'(STACK_DEPTH));
  assign empty = (r_sp == '0);
  assign dout  = r_mem[w_top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
    end else if (push && !full) begin
      r_mem[w_wr_idx] <= din;
      r_sp            <= r_sp + {{(SP_W-1){1'b0}}, 1'b1};
    end else if (pop && !empty) begin
      r_sp <= w_sp_dec;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - program counter and branch decision unit
// Purpose: advances the PC, resolves conditional branches against latched
//          compare flags, and manages CALL/RET through a return stack.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cmp_valid, cmp_res   compare result to latch into {zf, nf}
//   op_valid, pc_op      branch operation request
//   target               absolute jump/call destination
//   stall                freezes all state, forces taken low
//   pc                   registered program counter
//   taken                one-cycle pulse when the accepted op redirected the PC
//   stack_err            sticky return-stack overflow/underflow flag
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmp_valid,
  input  logic [DATA_W-1:0] cmp_res,
  input  logic              op_valid,
  input  op_t               pc_op,
  input  logic [PC_W-1:0]   target,
  input  logic              stall,
  output logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic              stack_err
);

  logic [PC_W-1:0] r_pc;
  logic            r_taken;
  logic            r_err;
  logic            r_zf;
  logic            r_nf;

  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_stk_dout;
  logic            w_stk_full;
  logic            w_stk_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_take;
  logic            w_err_set;

  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc        = r_pc;
  assign taken     = r_taken;
  assign stack_err = r_err;

  // Decision uses the flags registered before this edge, so a compare
  // arriving together with a branch only affects later branches.
  always_comb begin
    w_take    = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (op_valid && !stall) begin
      case (pc_op)
        OP_JMP:  w_take = 1'b1;
        OP_JZ:   w_take = r_zf;
        OP_JNZ:  w_take = !r_zf;
        OP_NOP:  w_take = 1'b0;
        OP_JGT:  w_take = !r_zf && !r_nf;
        OP_JLT:  w_take = r_nf;
        OP_CALL: begin
          // Overflowing CALL degrades to NOP and only raises the error.
          if (w_stk_full) begin
            w_err_set = 1'b1;
          end else begin
            w_push = 1'b1;
            w_take = 1'b1;
          end
        end
        OP_RET: begin
          if (w_stk_empty) begin
            w_err_set = 1'b1;
          end else begin
            w_pop  = 1'b1;
            w_take = 1'b1;
          end
        end
        default: w_take = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_take) w_pc_next = w_pop ? w_stk_dout : target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
      r_zf    <= 1'b0;
      r_nf    <= 1'b0;
    end else if (stall) begin
      r_taken <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_taken <= w_take;
      if (w_err_set) r_err <= 1'b1;
      if (cmp_valid) begin
        r_zf <= (cmp_res == '0);
        r_nf <= cmp_res[DATA_W-1];
      end
    end
  end

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .dout  (w_stk_dout),
    .full  (w_stk_full),
    .empty (w_stk_empty)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmp_valid = 1'b0;
  logic [7:0] cmp_res = '0;
  logic       op_valid = 1'b0;
  logic [2:0] pc_op = '0;
  logic [7:0] target = '0;
  logic       stall = 1'b0;
  logic [7:0] pc;
  logic       taken;
  logic       stack_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_pc;
  bit m_taken, m_err, m_zf, m_nf;
  int m_stk[$];

  branch_ctrl #(.DATA_W(8), .PC_W(8), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmp_valid (cmp_valid),
    .cmp_res   (cmp_res),
    .op_valid  (op_valid),
    .pc_op     (pc_op),
    .target    (target),
    .stall     (stall),
    .pc        (pc),
    .taken     (taken),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_taken = 0; m_err = 0; m_zf = 0; m_nf = 0;
    m_stk.delete();
  endtask

  task automatic model_step();
    int nxt;
    int dest;
    bit tk;
    if (rst) begin
      model_reset();
      return;
    end
    if (stall) begin
      m_taken = 0;
      return;
    end
    nxt  = (m_pc + 1) % 256;
    dest = int'(target);
    tk   = 0;
    if (op_valid) begin
      case (int'(pc_op))
        0: tk = 1;
        1: tk = m_zf;
        2: tk = !m_zf;
        3: tk = 0;
        4: tk = !m_zf && !m_nf;
        5: tk = m_nf;
        6: if (m_stk.size() < 4) begin m_stk.push_back(nxt); tk = 1; end else m_err = 1;
        default: if (m_stk.size() > 0) begin dest = m_stk.pop_back(); tk = 1; end else m_err = 1;
      endcase
    end
    m_pc    = tk ? dest : nxt;
    m_taken = tk;
    if (cmp_valid) begin
      m_zf = (cmp_res == 8'h00);
      m_nf = cmp_res[7];
    end
  endtask

  // Inputs are stable across the edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit v, input int op, input int tgt);
    op_valid = v;
    pc_op    = 3'(op);
    target   = 8'(tgt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_valid = 0; stall = 0;
    set_op(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(1, 0, 8'h55);
    #3;
    n_vec += 3;
    if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h want 00", pc); end
    if (taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %b want 0", taken); end
    if (stack_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", stack_err); end
    model_reset();
    @(posedge clk);
    #1;
    n_vec++;
    if (pc !== 8'h00) begin n_err++; $display("FAIL reset_hold_pc got %h want 00", pc); end
    rst = 1'b0;
    set_op(1, 0, 8'h22);
    tick();
    n_vec += 2;
    if (pc !== 8'h22) begin n_err++; $display("FAIL first_op_pc got %h want 22", pc); end
    if (taken !== 1'b1) begin n_err++; $display("FAIL first_op_taken got %b want 1", taken); end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      tick();
      n_vec += 2;
      if (pc !== 8'((i + 1) % 256)) begin
        n_err++; $display("FAIL free_run_pc cycle %0d got %h want %h", i, pc, 8'((i + 1) % 256));
      end
      if (taken !== 1'b0) begin n_err++; $display("FAIL free_run_taken cycle %0d got %b want 0", i, taken); end
    end
  endtask

  task automatic test_cmp_branch();
    do_reset();
    cmp_valid = 1; cmp_res = 8'h00;
    tick();
    cmp_valid = 0;
    set_op(1, 1, 8'h40);
    tick();
    n_vec += 2;
    if (pc !== 8'h40) begin n_err++; $display("FAIL cmp_jz_pc got %h want 40", pc); end
    if (taken !== 1'b1) begin n_err++; $display("FAIL cmp_jz_taken got %b want 1", taken); end
    set_op(0, 0, 0);
    tick();
    n_vec += 2;
    if (pc !== 8'h41) begin n_err++; $display("FAIL cmp_after_pc got %h want 41", pc); end
    if (taken !== 1'b0) begin n_err++; $display("FAIL cmp_pulse_taken got %b want 0", taken); end
    cmp_valid = 1; cmp_res = 8'h85;
    set_op(0, 0, 0);
    tick();
    cmp_valid = 0;
    set_op(1, 5, 8'h70);
    tick();
    n_vec++;
    if (pc !== 8'h70) begin n_err++; $display("FAIL jlt_neg_pc got %h want 70", pc); end
    set_op(1, 4, 8'h10);
    tick();
    n_vec++;
    if (pc !== 8'h71) begin n_err++; $display("FAIL jgt_neg_pc got %h want 71", pc); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    cmp_valid = 1; cmp_res = 8'h05;
    tick();
    cmp_res = 8'h00;
    set_op(1, 1, 8'h40);
    tick();
    n_vec += 2;
    if (pc !== 8'h02) begin n_err++; $display("FAIL same_cycle_pc got %h want 02", pc); end
    if (taken !== 1'b0) begin n_err++; $display("FAIL same_cycle_taken got %b want 0", taken); end
    cmp_valid = 0;
    tick();
    n_vec += 2;
    if (pc !== 8'h40) begin n_err++; $display("FAIL next_jz_pc got %h want 40", pc); end
    if (taken !== 1'b1) begin n_err++; $display("FAIL next_jz_taken got %b want 1", taken); end
  endtask

  task automatic test_nested_calls();
    int tg[4];
    int rets[4];
    int prev;
    do_reset();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      tg[k] = 8'h20 + 8'h10 * k;
      rets[k] = prev + 1;
      set_op(1, 6, tg[k]);
      tick();
      n_vec += 3;
      if (pc !== 8'(tg[k])) begin n_err++; $display("FAIL call%0d_pc got %h want %h", k, pc, 8'(tg[k])); end
      if (taken !== 1'b1) begin n_err++; $display("FAIL call%0d_taken got %b want 1", k, taken); end
      if (stack_err !== 1'b0) begin n_err++; $display("FAIL call%0d_err got %b want 0", k, stack_err); end
      prev = tg[k];
    end
    set_op(1, 6, 8'h60);
    tick();
    n_vec += 3;
    if (pc !== 8'h51) begin n_err++; $display("FAIL call_ovf_pc got %h want 51", pc); end
    if (taken !== 1'b0) begin n_err++; $display("FAIL call_ovf_taken got %b want 0", taken); end
    if (stack_err !== 1'b1) begin n_err++; $display("FAIL call_ovf_err got %b want 1", stack_err); end
    for (int k = 3; k >= 0; k--) begin
      set_op(1, 7, 8'hEE);
      tick();
      n_vec += 2;
      if (pc !== 8'(rets[k])) begin n_err++; $display("FAIL ret%0d_pc got %h want %h", k, pc, 8'(rets[k])); end
      if (taken !== 1'b1) begin n_err++; $display("FAIL ret%0d_taken got %b want 1", k, taken); end
    end
    tick();
    n_vec += 3;
    if (pc !== 8'h02) begin n_err++; $display("FAIL ret_udf_pc got %h want 02", pc); end
    if (taken !== 1'b0) begin n_err++; $display("FAIL ret_udf_taken got %b want 0", taken); end
    if (stack_err !== 1'b1) begin n_err++; $display("FAIL ret_udf_err got %b want 1", stack_err); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    stall = 1;
    set_op(1, 0, 8'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec += 2;
      if (pc !== 8'h00) begin n_err++; $display("FAIL stall%0d_pc got %h want 00", i, pc); end
      if (taken !== 1'b0) begin n_err++; $display("FAIL stall%0d_taken got %b want 0", i, taken); end
    end
    stall = 0;
    tick();
    n_vec += 2;
    if (pc !== 8'h10) begin n_err++; $display("FAIL stall_release_pc got %h want 10", pc); end
    if (taken !== 1'b1) begin n_err++; $display("FAIL stall_release_taken got %b want 1", taken); end
    set_op(0, 0, 0);
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec += 2;
    if (pc !== 8'h00) begin n_err++; $display("FAIL async_rst_pc got %h want 00", pc); end
    if (taken !== 1'b0) begin n_err++; $display("FAIL async_rst_taken got %b want 0", taken); end
    set_op(1, 0, 8'h33);
    #1;
    rst = 1'b0;
    tick();
    n_vec++;
    if (pc !== 8'h33) begin n_err++; $display("FAIL post_rst_op_pc got %h want 33", pc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stall     = ($urandom_range(0, 7) == 0);
      cmp_valid = ($urandom_range(0, 2) == 0);
      cmp_res   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      set_op($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255));
      tick();
      n_vec += 3;
      if (pc !== 8'(m_pc)) begin n_err++; $display("FAIL rand_pc cycle %0d got %h want %h", i, pc, 8'(m_pc)); end
      if (taken !== m_taken) begin n_err++; $display("FAIL rand_taken cycle %0d got %b want %b", i, taken, m_taken); end
      if (stack_err !== m_err) begin n_err++; $display("FAIL rand_err cycle %0d got %b want %b", i, stack_err, m_err); end
    end
    stall = 0; cmp_valid = 0;
    set_op(0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_cmp_branch();
    test_same_cycle();
    test_nested_calls();
    test_stall_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
